// File: rtl/gradient_aggregator.sv
// Sums NUM_WORKERS gradient batches element-wise into an on-chip line buffer,
// then streams the aggregated lines out with TLAST on the final one.
`timescale 1ns/1ps
module gradient_aggregator #(
  parameter int LANES       = 16,
  parameter int MAX_LINES   = 64,
  parameter int NUM_WORKERS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_TVALID,
  input  logic [LANES*32-1:0]   in_TDATA,
  output logic                  in_TREADY,
  input  logic                  in_batch_ending,
  input  logic [31:0]           in_N,
  output logic                  out_TVALID,
  output logic [LANES*32-1:0]   out_TDATA,
  output logic                  out_TLAST,
  input  logic                  out_TREADY,
  output logic [7:0]            workers_seen,
  output logic                  err_n_mismatch,
  output logic                  err_overflow
);
  localparam int DATA_W = LANES * 32;
  localparam int AW     = $clog2(MAX_LINES);
  localparam int IW     = $clog2(MAX_LINES + 1);

  typedef enum logic {ACCUM, DRAIN} state_t;

  // Handshake: a beat moves on a port only in a cycle where both its VALID and
  // READY are high; VALID/data/LAST never change while VALID is high and READY low.
  state_t              state;
  logic [IW-1:0]       wr_idx;
  logic [IW-1:0]       rd_idx;
  logic [IW-1:0]       rd_nxt;
  logic [IW-1:0]       round_lines;
  logic [31:0]         round_n;
  logic [DATA_W-1:0]   acc [MAX_LINES];
  logic [DATA_W-1:0]   rd_line;
  logic [DATA_W-1:0]   wr_line;
  logic [31:0]         header;
  logic                in_xfer;
  logic                wr_en;
  logic                first_worker;
  logic                last_worker;

  assign in_TREADY    = (state == ACCUM);
  assign in_xfer      = in_TVALID && in_TREADY;
  assign first_worker = (workers_seen == 8'd0);
  assign last_worker  = (workers_seen == 8'(NUM_WORKERS - 1));
  assign wr_en        = in_xfer && (wr_idx != IW'(MAX_LINES));
  assign header       = first_worker ? in_N : round_n;
  assign rd_line      = acc[wr_idx[AW-1:0]];
  assign rd_nxt       = rd_idx + 1'b1;

  // Lane 0 of line 0 carries the round's element count rather than gradient data.
  always_comb begin
    wr_line = '0;
    for (int l = 0; l < LANES; l++) begin
      if (first_worker)
        wr_line[l*32 +: 32] = in_TDATA[l*32 +: 32];
      else
        wr_line[l*32 +: 32] = rd_line[l*32 +: 32] + in_TDATA[l*32 +: 32];
    end
    if (wr_idx == '0)
      wr_line[31:0] = header;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en)
      acc[wr_idx[AW-1:0]] <= wr_line;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ACCUM;
      wr_idx         <= '0;
      rd_idx         <= '0;
      round_lines    <= '0;
      round_n        <= '0;
      workers_seen   <= '0;
      err_n_mismatch <= 1'b0;
      err_overflow   <= 1'b0;
      out_TVALID     <= 1'b0;
      out_TDATA      <= '0;
      out_TLAST      <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_xfer) begin
            if (wr_idx == '0) begin
              if (first_worker)
                round_n <= in_N;
              else if (in_N != round_n)
                err_n_mismatch <= 1'b1;
            end
            if (!wr_en)
              err_overflow <= 1'b1;
            if (in_batch_ending) begin
              wr_idx       <= '0;
              workers_seen <= workers_seen + 8'd1;
              if (first_worker)
                round_lines <= (wr_idx == IW'(MAX_LINES)) ? IW'(MAX_LINES) : wr_idx + 1'b1;
              if (last_worker) begin
                state  <= DRAIN;
                rd_idx <= '0;
              end
            end else if (wr_en) begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!out_TVALID) begin
            out_TVALID <= 1'b1;
            out_TDATA  <= acc[rd_idx[AW-1:0]];
            out_TLAST  <= (rd_idx == round_lines - 1'b1);
          end else if (out_TREADY) begin
            if (out_TLAST) begin
              out_TVALID   <= 1'b0;
              out_TLAST    <= 1'b0;
              workers_seen <= '0;
              state        <= ACCUM;
            end else begin
              rd_idx    <= rd_nxt;
              out_TDATA <= acc[rd_nxt[AW-1:0]];
              out_TLAST <= (rd_nxt == round_lines - 1'b1);
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule
